// File: rtl/rom_flex_pkg.sv
// Shared sizing helpers for the tiled ROM: address width and tile-grid geometry.
package rom_flex_pkg;

  // Words walked per inner loop when building tile contents at elaboration.
  localparam int INIT_BLK = 32;

  // 0 for x <= 1, otherwise ceil(log2(x)).
  function automatic int log2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r = r + 1;
    return r;
  endfunction

  // Words held by one tile.
  function automatic int tile_words(input int bits_au);
    return 1 << bits_au;
  endfunction

  // Tile rows needed to cover depth words.
  function automatic int tile_rows(input int depth, input int bits_au);
    return (depth + tile_words(bits_au) - 1) / tile_words(bits_au);
  endfunction

  // Tile columns needed to cover bits_d data bits.
  function automatic int tile_cols(input int bits_d, input int bits_du);
    return (bits_d + bits_du - 1) / bits_du;
  endfunction

  // Width of the row-select field; kept at least 1 bit so it always exists.
  function automatic int row_bits(input int bits_a, input int bits_au);
    return (bits_a > bits_au) ? (bits_a - bits_au) : 1;
  endfunction

  // Data bits actually carried by column c; the top column may be partial.
  function automatic int col_width(input int bits_d, input int bits_du, input int c);
    return ((bits_d - c * bits_du) < bits_du) ? (bits_d - c * bits_du) : bits_du;
  endfunction

endpackage

// File: rtl/rom_flex_tile.sv
// One dual-read BRAM tile of the ROM. Contents are derived from the global
// value list using this tile's row/column position; only the data bits that
// fall inside the word are stored, the padding above the word is dropped.
module rom_flex_tile
  import rom_flex_pkg::*;
#(
  parameter int BITS_AU        = 10,
  parameter int BITS_DU        = 18,
  parameter int BITS_Q         = 18,
  parameter int DEPTH          = 1025,
  parameter int BITS_D         = 99,
  parameter int ROMVALUE_COUNT = 1,
  parameter logic [BITS_D-1:0] ROMVALUE_ARRAY [ROMVALUE_COUNT] = '{default: '0},
  parameter int ROW            = 0,
  parameter int COL            = 0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [BITS_AU-1:0] addra,
  input  logic [BITS_AU-1:0] addrb,
  output logic [BITS_Q-1:0]  qa,
  output logic [BITS_Q-1:0]  qb
);

  localparam int TILE_WORDS = tile_words(BITS_AU);

  // Build the tile image: word i holds global word ROW*TILE_WORDS+i, zero past DEPTH.
  // Nested loops keep each elaboration-time loop short.
  function automatic logic [TILE_WORDS*BITS_Q-1:0] init_flat();
    logic [TILE_WORDS*BITS_Q-1:0] flat;
    logic [BITS_D-1:0]            word;
    int                           i;
    int                           g;
    flat = '0;
    for (int b = 0; b < TILE_WORDS; b += INIT_BLK) begin
      for (int k = 0; k < INIT_BLK; k++) begin
        i = b + k;
        g = ROW * TILE_WORDS + i;
        if ((i < TILE_WORDS) && (g < DEPTH)) begin
          word = ROMVALUE_ARRAY[g % ROMVALUE_COUNT];
          flat[i*BITS_Q +: BITS_Q] = word[COL*BITS_DU +: BITS_Q];
        end
      end
    end
    return flat;
  endfunction

  localparam logic [TILE_WORDS*BITS_Q-1:0] INIT_FLAT = init_flat();

  logic [BITS_Q-1:0] mem_s [TILE_WORDS];
  logic [BITS_Q-1:0] qa_r;
  logic [BITS_Q-1:0] qb_r;

  for (genvar i = 0; i < TILE_WORDS; i++) begin : g_init
    assign mem_s[i] = INIT_FLAT[i*BITS_Q +: BITS_Q];
  end

  // Registered reads on both ports; output registers clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_r <= '0;
      qb_r <= '0;
    end else begin
      qa_r <= mem_s[addra];
      qb_r <= mem_s[addrb];
    end
  end

  assign qa = qa_r;
  assign qb = qb_r;

endmodule

// File: rtl/rom_flex.sv
// Dual-read-port ROM of arbitrary depth/width built from a grid of BRAM tiles.
// Low address bits index inside a tile, high bits pick the tile row; the row
// select is registered with the tile read so the output mux lines up with data.
module rom_flex
  import rom_flex_pkg::*;
#(
  parameter int BITS_AU        = 10,
  parameter int BITS_DU        = 18,
  parameter int DEPTH          = 1025,
  parameter int BITS_D         = 99,
  parameter int ROMVALUE_COUNT = 1,
  parameter logic [BITS_D-1:0] ROMVALUE_ARRAY [ROMVALUE_COUNT] = '{default: '0},
  localparam int BITS_A        = log2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_A-1:0] addra,
  output logic [BITS_D-1:0] rdataa,
  input  logic [BITS_A-1:0] addrb,
  output logic [BITS_D-1:0] rdatab
);

  localparam int ROWS   = tile_rows(DEPTH, BITS_AU);
  localparam int COLS   = tile_cols(BITS_D, BITS_DU);
  localparam int BITS_R = row_bits(BITS_A, BITS_AU);

  logic [BITS_AU-1:0]     tile_addra_s;
  logic [BITS_AU-1:0]     tile_addrb_s;
  logic [BITS_R-1:0]      row_a_s;
  logic [BITS_R-1:0]      row_b_s;
  logic [BITS_R-1:0]      row_a_r;
  logic [BITS_R-1:0]      row_b_r;
  logic [ROWS*BITS_D-1:0] row_data_a_s;
  logic [ROWS*BITS_D-1:0] row_data_b_s;
  logic [BITS_D-1:0]      mux_a_s;
  logic [BITS_D-1:0]      mux_b_s;

  // Split the address; a ROM no deeper than one tile has a single row.
  if (BITS_A > BITS_AU) begin : g_split
    assign tile_addra_s = addra[BITS_AU-1:0];
    assign tile_addrb_s = addrb[BITS_AU-1:0];
    assign row_a_s      = addra[BITS_A-1:BITS_AU];
    assign row_b_s      = addrb[BITS_A-1:BITS_AU];
  end else begin : g_narrow
    assign tile_addra_s = BITS_AU'(addra);
    assign tile_addrb_s = BITS_AU'(addrb);
    assign row_a_s      = '0;
    assign row_b_s      = '0;
  end

  // Row selects travel with the tile read so the mux sees them in the data cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_a_r <= '0;
      row_b_r <= '0;
    end else begin
      row_a_r <= row_a_s;
      row_b_r <= row_b_s;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int BITS_Q = col_width(BITS_D, BITS_DU, c);
      logic [BITS_Q-1:0] qa_s;
      logic [BITS_Q-1:0] qb_s;

      rom_flex_tile #(
        .BITS_AU        (BITS_AU),
        .BITS_DU        (BITS_DU),
        .BITS_Q         (BITS_Q),
        .DEPTH          (DEPTH),
        .BITS_D         (BITS_D),
        .ROMVALUE_COUNT (ROMVALUE_COUNT),
        .ROMVALUE_ARRAY (ROMVALUE_ARRAY),
        .ROW            (r),
        .COL            (c)
      ) u_tile (
        .clk   (clk),
        .rst   (rst),
        .addra (tile_addra_s),
        .addrb (tile_addrb_s),
        .qa    (qa_s),
        .qb    (qb_s)
      );

      assign row_data_a_s[r*BITS_D + c*BITS_DU +: BITS_Q] = qa_s;
      assign row_data_b_s[r*BITS_D + c*BITS_DU +: BITS_Q] = qb_s;
    end
  end

  // Output mux per port; a row code with no tiles behind it reads as zero.
  always_comb begin
    mux_a_s = '0;
    mux_b_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      mux_a_s = mux_a_s | ((row_a_r == BITS_R'(r)) ? row_data_a_s[r*BITS_D +: BITS_D] : '0);
      mux_b_s = mux_b_s | ((row_b_r == BITS_R'(r)) ? row_data_b_s[r*BITS_D +: BITS_D] : '0);
    end
  end

  assign rdataa = mux_a_s;
  assign rdatab = mux_b_s;

endmodule

// File: tb/tb_rom_flex.sv
// Directed bench for rom_flex in its default geometry with a 71-entry list.
module tb_rom_flex;

  localparam int N = 71;

  // Filler entries: distinct 99-bit patterns derived from the index.
  function automatic logic [98:0] f(input int k);
    logic [31:0] x;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    x = k;
    a = x * 32'h9E3779B9 + 32'h01234567;
    b = (x ^ 32'h5BD1E995) * 32'h27D4EB2F;
    c = x * 32'h85EBCA6B + 32'hC2B2AE35;
    return {x[2:0] ^ 3'd5, a, b, c};
  endfunction

  localparam logic [127:0] E0_FULL  = 128'h698c912d1a87212068ad83e89034cdac;
  localparam logic [127:0] E2_FULL  = 128'haecb122c2db8b331d6d261c4d7758aa6;
  localparam logic [127:0] E30_FULL = 128'h4a06515d3d4b2e457156a42a57cdbf6e;
  localparam logic [98:0]  E0  = E0_FULL[98:0];
  localparam logic [98:0]  E2  = E2_FULL[98:0];
  localparam logic [98:0]  E30 = E30_FULL[98:0];

  localparam logic [98:0] LIST [N] = '{
    E0,     f(1),   E2,     f(3),   f(4),   f(5),   f(6),   f(7),
    f(8),   f(9),   f(10),  f(11),  f(12),  f(13),  f(14),  f(15),
    f(16),  f(17),  f(18),  f(19),  f(20),  f(21),  f(22),  f(23),
    f(24),  f(25),  f(26),  f(27),  f(28),  f(29),  E30,    f(31),
    f(32),  f(33),  f(34),  f(35),  f(36),  f(37),  f(38),  f(39),
    f(40),  f(41),  f(42),  f(43),  f(44),  f(45),  f(46),  f(47),
    f(48),  f(49),  f(50),  f(51),  f(52),  f(53),  f(54),  f(55),
    f(56),  f(57),  f(58),  f(59),  f(60),  f(61),  f(62),  f(63),
    f(64),  f(65),  f(66),  f(67),  f(68),  f(69),  f(70)
  };

  // Hand-truncated words for entries 0, 2 and 30.
  localparam logic [98:0] H0  = 99'h5_1a87212068ad83e89034cdac;
  localparam logic [98:0] H2  = 99'h4_2db8b331d6d261c4d7758aa6;
  localparam logic [98:0] H30 = 99'h5_3d4b2e457156a42a57cdbf6e;
  localparam logic [98:0] Z   = 99'h0;

  logic        clk;
  logic        rst;
  logic [10:0] addra;
  logic [10:0] addrb;
  logic [98:0] rdataa;
  logic [98:0] rdatab;

  int vectors    = 0;
  int miscompares = 0;

  rom_flex #(
    .BITS_AU        (10),
    .BITS_DU        (18),
    .DEPTH          (1025),
    .BITS_D         (99),
    .ROMVALUE_COUNT (N),
    .ROMVALUE_ARRAY (LIST)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addra  (addra),
    .rdataa (rdataa),
    .addrb  (addrb),
    .rdatab (rdatab)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [98:0] model(input int a);
    if (a < 1025) return LIST[a % N];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [98:0] obs, input logic [98:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    addra = 11'd0;
    addrb = 11'd0;
    tick();
    tick();
    check("reset_a", rdataa, Z);
    check("reset_b", rdatab, Z);
    addra = 11'd5;
    addrb = 11'd9;
    tick();
    check("reset_hold_a", rdataa, Z);
    check("reset_hold_b", rdatab, Z);

    // Release; truncation and one-cycle latency.
    rst   = 1'b0;
    addra = 11'd0;
    addrb = 11'd2;
    tick();
    check("trunc_a0", rdataa, H0);
    check("trunc_b2", rdatab, H2);

    addra = 11'd30;
    addrb = 11'd1024;
    tick();
    check("entry30_a", rdataa, H30);
    check("row1_b1024", rdatab, H30);

    // Reset mid-cycle clears outputs without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_a", rdataa, Z);
    check("async_rst_b", rdatab, Z);
    tick();
    check("rst_edge_a", rdataa, Z);
    check("rst_edge_b", rdatab, Z);
    rst   = 1'b0;
    addra = 11'd2;
    addrb = 11'd1023;
    tick();
    check("post_rst_a2", rdataa, H2);
    check("row0_b1023", rdatab, model(1023));

    // Out of range on A while B reads entry 0.
    addra = 11'd1025;
    addrb = 11'd71;
    tick();
    check("oor_a1025", rdataa, Z);
    check("oor_b71", rdatab, H0);
    addra = 11'd2047;
    tick();
    check("oor_a2047", rdataa, Z);
    check("oor_b71_again", rdatab, H0);

    // Same-address collision.
    addra = 11'd500;
    addrb = 11'd500;
    tick();
    check("coll_a500", rdataa, model(500));
    check("coll_b500", rdatab, model(500));

    // Wrap from last word to first.
    addra = 11'd1024;
    tick();
    check("wrap_a1024", rdataa, H30);
    addra = 11'd0;
    tick();
    check("wrap_a0", rdataa, H0);

    // Output holds until the next edge after the address changes.
    addra = 11'd7;
    #2;
    check("hold_a", rdataa, H0);
    tick();
    check("next_a7", rdataa, model(7));

    // Back-to-back sweep, both ports, B offset.
    for (int i = 0; i <= 2050; i++) begin
      addra = 11'(i % 1025);
      addrb = 11'((i + 37) % 1025);
      tick();
      check("sweep_a", rdataa, model(i % 1025));
      check("sweep_b", rdatab, model((i + 37) % 1025));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
